// File: rtl/pet_needs_fsm.sv
// Virtual pet with NUM_NEEDS saturating need levels that decay on a programmable
// tick. Three button pulses browse, feed, play and sleep; a low level sum kills the pet.
module pet_needs_fsm #(
  parameter int NUM_NEEDS     = 5,
  parameter int LEVEL_W       = 3,
  parameter int TIMER_W       = 32,
  parameter int BASE_INTERVAL = 50000000,
  parameter int FOOD_IDX      = 1,
  parameter int SLEEP_IDX     = 2,
  parameter int PLAY_IDX      = 3,
  parameter int HEALTH_IDX    = 4,
  parameter int DEATH_SUM     = 5,
  parameter int SLEEP_TICKS   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            btn_next,
  input  logic                            btn_act,
  input  logic                            btn_prev,
  input  logic                            test,
  input  logic [1:0]                      color,
  input  logic [1:0]                      time_control,
  input  logic                            luz,
  output logic [1:0]                      state_code,
  output logic [$clog2(NUM_NEEDS)-1:0]    sel,
  output logic [LEVEL_W-1:0]              level_out,
  output logic [NUM_NEEDS*LEVEL_W-1:0]    levels_flat,
  output logic                            tick
);

  localparam int SEL_W  = $clog2(NUM_NEEDS);
  localparam int SUM_W  = LEVEL_W + SEL_W + 1;
  localparam int SCNT_W = $clog2(SLEEP_TICKS + 1);
  localparam logic [LEVEL_W-1:0] LMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_SLEEP  = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 tick_q, tick_d;
  logic [SCNT_W-1:0]    sleep_cnt_q, sleep_cnt_d;
  logic [1:0]           color_exp_q, color_exp_d;
  logic [LEVEL_W-1:0]   level_q [NUM_NEEDS];
  logic [LEVEL_W-1:0]   level_d [NUM_NEEDS];

  logic [LEVEL_W-1:0]   level_dec [NUM_NEEDS];
  logic [LEVEL_W-1:0]   level_upd [NUM_NEEDS];
  logic [NUM_NEEDS-1:0] inc_vec, dec_vec, max_vec, sel_onehot;
  logic                 decay_en, upd_en, force_max;

  logic [TIMER_W-1:0]   interval, limit;
  logic                 counting, tick_now, any_btn, starving;
  logic [SUM_W-1:0]     level_sum;
  logic [SCNT_W-1:0]    sleep_cnt_inc;

  // A zero interval (shifted past the base) ticks every cycle rather than underflowing.
  assign interval      = TIMER_W'(BASE_INTERVAL) >> {time_control, 1'b0};
  assign limit         = (interval == '0) ? '0 : interval - 1'b1;
  assign counting      = (state_q == S_SELECT) || (state_q == S_SLEEP);
  assign tick_now      = counting && (timer_q >= limit);
  assign any_btn       = btn_next | btn_act | btn_prev;
  assign sleep_cnt_inc = sleep_cnt_q + 1'b1;

  always_comb begin
    level_sum = '0;
    for (int k = 0; k < NUM_NEEDS; k++) begin
      level_sum = level_sum + SUM_W'(level_q[k]);
    end
  end
  assign starving = (level_sum < SUM_W'(DEATH_SUM));

  // Per channel: decay first, then the action delta, each step saturating.
  generate
    for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_need
      assign sel_onehot[gi] = (sel_q == SEL_W'(gi));
      assign level_dec[gi]  = (decay_en && level_q[gi] != '0) ? level_q[gi] - 1'b1 : level_q[gi];
      assign level_upd[gi]  = max_vec[gi] ? LMAX :
                              (inc_vec[gi] && !dec_vec[gi] && level_dec[gi] != LMAX) ? level_dec[gi] + 1'b1 :
                              (dec_vec[gi] && !inc_vec[gi] && level_dec[gi] != '0)   ? level_dec[gi] - 1'b1 :
                              level_dec[gi];
      assign levels_flat[gi*LEVEL_W +: LEVEL_W] = level_q[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = '0;
    tick_d      = 1'b0;
    sleep_cnt_d = sleep_cnt_q;
    color_exp_d = color_exp_q;
    inc_vec     = '0;
    dec_vec     = '0;
    max_vec     = '0;
    decay_en    = 1'b0;
    upd_en      = 1'b0;
    force_max   = 1'b0;

    if (counting) begin
      timer_d = tick_now ? '0 : timer_q + 1'b1;
      tick_d  = tick_now;
    end

    case (state_q)
      S_IDLE: begin
        force_max = 1'b1;
        if (any_btn) begin
          state_d = S_SELECT;
          sel_d   = '0;
        end
      end

      S_SELECT: begin
        if (!test && starving) begin
          state_d = S_DEAD;
          timer_d = '0;
          tick_d  = 1'b0;
        end else begin
          decay_en = tick_now;
          upd_en   = 1'b1;
          if (btn_next && !btn_prev) begin
            sel_d = (sel_q == SEL_W'(NUM_NEEDS - 1)) ? '0 : sel_q + 1'b1;
          end else if (btn_prev && !btn_next) begin
            sel_d = (sel_q == '0) ? SEL_W'(NUM_NEEDS - 1) : sel_q - 1'b1;
          end
          if (btn_act) begin
            if (test) begin
              inc_vec = sel_onehot;
            end else if (sel_q == SEL_W'(SLEEP_IDX) && luz) begin
              state_d     = S_SLEEP;
              sleep_cnt_d = '0;
            end else if (sel_q == SEL_W'(FOOD_IDX)) begin
              if (color == color_exp_q) begin
                inc_vec[FOOD_IDX] = 1'b1;
              end else begin
                dec_vec[FOOD_IDX]   = 1'b1;
                dec_vec[HEALTH_IDX] = 1'b1;
              end
              color_exp_d = color_exp_q + 2'd1;
            end else if (sel_q == SEL_W'(PLAY_IDX)) begin
              inc_vec[PLAY_IDX]  = 1'b1;
              dec_vec[FOOD_IDX]  = 1'b1;
              dec_vec[SLEEP_IDX] = 1'b1;
            end else begin
              inc_vec = sel_onehot;
            end
          end
        end
      end

      S_SLEEP: begin
        upd_en = 1'b1;
        if (tick_now) begin
          if (sleep_cnt_inc == SCNT_W'(SLEEP_TICKS)) begin
            max_vec[SLEEP_IDX]  = 1'b1;
            inc_vec[HEALTH_IDX] = 1'b1;
            state_d             = S_SELECT;
            sleep_cnt_d         = '0;
          end else begin
            sleep_cnt_d = sleep_cnt_inc;
          end
        end else if (btn_next || btn_prev) begin
          state_d = S_SELECT;
        end
      end

      default: begin
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_NEEDS; k++) begin
      level_d[k] = level_q[k];
      if (force_max) begin
        level_d[k] = LMAX;
      end else if (upd_en) begin
        level_d[k] = level_upd[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      tick_q      <= 1'b0;
      sleep_cnt_q <= '0;
      color_exp_q <= 2'd0;
      for (int k = 0; k < NUM_NEEDS; k++) begin
        level_q[k] <= LMAX;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      tick_q      <= tick_d;
      sleep_cnt_q <= sleep_cnt_d;
      color_exp_q <= color_exp_d;
      for (int k = 0; k < NUM_NEEDS; k++) begin
        level_q[k] <= level_d[k];
      end
    end
  end

  assign state_code = state_q;
  assign sel        = sel_q;
  assign level_out  = level_q[sel_q];
  assign tick       = tick_q;

endmodule

// File: tb/tb_pet_needs_fsm.sv
// Directed bench for pet_needs_fsm with a 16-cycle base tick; inputs change and
// outputs are sampled on the falling clock edge.
module tb_pet_needs_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_next = 1'b0, btn_act = 1'b0, btn_prev = 1'b0;
  logic        test = 1'b0, luz = 1'b0;
  logic [1:0]  color = 2'd0, time_control = 2'd0;
  logic [1:0]  state_code;
  logic [2:0]  sel;
  logic [2:0]  level_out;
  logic [14:0] levels_flat;
  logic        tick;

  int checks = 0;
  int failures = 0;

  pet_needs_fsm #(.BASE_INTERVAL(16)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_act(btn_act), .btn_prev(btn_prev),
    .test(test), .color(color), .time_control(time_control), .luz(luz),
    .state_code(state_code), .sel(sel), .level_out(level_out),
    .levels_flat(levels_flat), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // One button transaction: inputs held across exactly one rising edge.
  task automatic pulse(input logic n, input logic a, input logic p);
    btn_next = n; btn_act = a; btn_prev = p;
    @(negedge clk);
    btn_next = 1'b0; btn_act = 1'b0; btn_prev = 1'b0;
    $display("[%0t] btn n=%0b a=%0b p=%0b -> state=%0d sel=%0d levels=%h tick=%0b",
             $time, n, a, p, state_code, sel, levels_flat, tick);
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s tick_timeout: tick=%0b after 100 cycles, required 1", tag, tick);
    end
  endtask

  // Reset is checked before any rising edge so only the asynchronous path can clear state.
  task automatic test_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    btn_next = 0; btn_act = 0; btn_prev = 0; test = 0; luz = 0; color = 0; time_control = 0;
    #1;
    checks++; if (state_code !== 2'd0) begin failures++; $display("FAIL %s reset_state: got %0d want 0", tag, state_code); end
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL %s reset_sel: got %0d want 0", tag, sel); end
    checks++; if (levels_flat !== pk(7,7,7,7,7)) begin failures++; $display("FAIL %s reset_levels: got %h want %h", tag, levels_flat, pk(7,7,7,7,7)); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL %s reset_tick: got %0b want 0", tag, tick); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state_code !== 2'd0) begin failures++; $display("FAIL %s idle_hold: got %0d want 0", tag, state_code); end
  endtask

  task automatic test_tick_basic();
    test_reset("tick_basic");
    pulse(0, 1, 0);
    checks++; if (state_code !== 2'd1 || sel !== 3'd0) begin failures++; $display("FAIL enter_select: state=%0d sel=%0d want 1/0", state_code, sel); end
    checks++; if (levels_flat !== pk(7,7,7,7,7)) begin failures++; $display("FAIL enter_levels: got %h want %h", levels_flat, pk(7,7,7,7,7)); end
    repeat (15) @(negedge clk);
    checks++; if (tick !== 1'b0 || level_out !== 3'd7) begin failures++; $display("FAIL early_tick: tick=%0b level=%0d want 0/7", tick, level_out); end
    @(negedge clk);
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL tick16: got %0b want 1", tick); end
    checks++; if (levels_flat !== pk(6,6,6,6,6)) begin failures++; $display("FAIL decay16: got %h want %h", levels_flat, pk(6,6,6,6,6)); end
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL tick_one_cycle: got %0b want 0", tick); end
  endtask

  task automatic test_tick_act();
    test_reset("tick_act");
    pulse(0, 1, 0);
    repeat (15) @(negedge clk);
    pulse(0, 1, 0);
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL tick_act_tick: got %0b want 1", tick); end
    checks++; if (levels_flat !== pk(7,6,6,6,6)) begin failures++; $display("FAIL tick_act_levels: got %h want %h", levels_flat, pk(7,6,6,6,6)); end
  endtask

  task automatic test_nav();
    test_reset("nav");
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    checks++; if (sel !== 3'd4 || level_out !== 3'd7) begin failures++; $display("FAIL nav_prev_wrap: sel=%0d level=%0d want 4/7", sel, level_out); end
    pulse(1, 0, 1);
    checks++; if (sel !== 3'd4) begin failures++; $display("FAIL nav_both: got %0d want 4", sel); end
    pulse(1, 0, 0);
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL nav_next_wrap: got %0d want 0", sel); end
    pulse(1, 0, 0);
    checks++; if (sel !== 3'd1) begin failures++; $display("FAIL nav_next: got %0d want 1", sel); end
  endtask

  task automatic test_food();
    test_reset("food");
    pulse(0, 1, 0);
    wait_tick("food_t1");
    wait_tick("food_t2");
    checks++; if (levels_flat !== pk(5,5,5,5,5)) begin failures++; $display("FAIL food_start: got %h want %h", levels_flat, pk(5,5,5,5,5)); end
    pulse(1, 0, 0);
    color = 2'd0;
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(5,6,5,5,5)) begin failures++; $display("FAIL food_match0: got %h want %h", levels_flat, pk(5,6,5,5,5)); end
    color = 2'd0;
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(5,5,5,5,4)) begin failures++; $display("FAIL food_mismatch: got %h want %h", levels_flat, pk(5,5,5,5,4)); end
    color = 2'd2;
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(5,6,5,5,4) || level_out !== 3'd6) begin failures++; $display("FAIL food_match2: got %h/%0d want %h/6", levels_flat, level_out, pk(5,6,5,5,4)); end
  endtask

  task automatic test_play();
    test_reset("play");
    pulse(0, 1, 0);
    wait_tick("play_t1");
    repeat (3) pulse(1, 0, 0);
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(6,5,5,7,6)) begin failures++; $display("FAIL play_act: got %h want %h", levels_flat, pk(6,5,5,7,6)); end
  endtask

  task automatic test_sleep();
    test_reset("sleep");
    pulse(0, 1, 0);
    wait_tick("sleep_t1");
    wait_tick("sleep_t2");
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    luz = 1'b0;
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(5,5,6,5,5) || state_code !== 2'd1) begin failures++; $display("FAIL sleep_luz0: got %h/%0d want %h/1", levels_flat, state_code, pk(5,5,6,5,5)); end
    luz = 1'b1;
    pulse(0, 1, 0);
    checks++; if (state_code !== 2'd2 || levels_flat !== pk(5,5,6,5,5)) begin failures++; $display("FAIL sleep_enter: got %0d/%h want 2/%h", state_code, levels_flat, pk(5,5,6,5,5)); end
    wait_tick("sleep_s1");
    checks++; if (state_code !== 2'd2 || levels_flat !== pk(5,5,6,5,5)) begin failures++; $display("FAIL sleep_nodecay: got %0d/%h want 2/%h", state_code, levels_flat, pk(5,5,6,5,5)); end
    wait_tick("sleep_s2");
    wait_tick("sleep_s3");
    checks++; if (state_code !== 2'd2) begin failures++; $display("FAIL sleep_early_wake: got %0d want 2", state_code); end
    wait_tick("sleep_s4");
    checks++; if (state_code !== 2'd1 || sel !== 3'd2) begin failures++; $display("FAIL sleep_wake: state=%0d sel=%0d want 1/2", state_code, sel); end
    checks++; if (levels_flat !== pk(5,5,7,5,6)) begin failures++; $display("FAIL sleep_bonus: got %h want %h", levels_flat, pk(5,5,7,5,6)); end
    pulse(0, 1, 0);
    checks++; if (state_code !== 2'd2) begin failures++; $display("FAIL sleep_reenter: got %0d want 2", state_code); end
    pulse(1, 0, 0);
    checks++; if (state_code !== 2'd1 || sel !== 3'd2 || levels_flat !== pk(5,5,7,5,6)) begin failures++; $display("FAIL sleep_btn_wake: state=%0d sel=%0d levels=%h want 1/2/%h", state_code, sel, levels_flat, pk(5,5,7,5,6)); end
    pulse(0, 1, 0);
    checks++; if (state_code !== 2'd2) begin failures++; $display("FAIL sleep_third: got %0d want 2", state_code); end
    test_reset("mid_sleep");
  endtask

  task automatic test_death();
    test_reset("death");
    time_control = 2'd1;
    pulse(0, 1, 0);
    repeat (6) wait_tick("death_t");
    checks++; if (levels_flat !== pk(1,1,1,1,1) || state_code !== 2'd1) begin failures++; $display("FAIL death_sum5: got %h/%0d want %h/1", levels_flat, state_code, pk(1,1,1,1,1)); end
    wait_tick("death_t7");
    checks++; if (levels_flat !== 15'd0 || state_code !== 2'd1) begin failures++; $display("FAIL death_t7: got %h/%0d want 0000/1", levels_flat, state_code); end
    @(negedge clk);
    checks++; if (state_code !== 2'd3) begin failures++; $display("FAIL death_state: got %0d want 3", state_code); end
    pulse(1, 1, 1);
    pulse(0, 0, 1);
    repeat (8) @(negedge clk);
    checks++; if (state_code !== 2'd3 || sel !== 3'd0 || levels_flat !== 15'd0 || tick !== 1'b0) begin failures++; $display("FAIL dead_frozen: state=%0d sel=%0d levels=%h tick=%0b want 3/0/0000/0", state_code, sel, levels_flat, tick); end
    test_reset("after_death");
  endtask

  task automatic test_test_mode();
    test_reset("testmode");
    test = 1'b1;
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(7,7,7,7,7) || state_code !== 2'd1) begin failures++; $display("FAIL tm_sat7: got %h/%0d want %h/1", levels_flat, state_code, pk(7,7,7,7,7)); end
    time_control = 2'd1;
    repeat (6) wait_tick("tm_t");
    time_control = 2'd0;
    checks++; if (levels_flat !== pk(1,1,1,1,1)) begin failures++; $display("FAIL tm_ones: got %h want %h", levels_flat, pk(1,1,1,1,1)); end
    repeat (3) pulse(1, 0, 0);
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(1,1,1,2,1)) begin failures++; $display("FAIL tm_play: got %h want %h", levels_flat, pk(1,1,1,2,1)); end
    pulse(0, 0, 1);
    luz = 1'b1;
    pulse(0, 1, 0);
    checks++; if (levels_flat !== pk(1,1,2,2,1) || state_code !== 2'd1) begin failures++; $display("FAIL tm_sleep_idx: got %h/%0d want %h/1", levels_flat, state_code, pk(1,1,2,2,1)); end
    wait_tick("tm_decay");
    @(negedge clk);
    @(negedge clk);
    checks++; if (state_code !== 2'd1 || levels_flat !== pk(0,0,1,1,0)) begin failures++; $display("FAIL tm_no_death: got %0d/%h want 1/%h", state_code, levels_flat, pk(0,0,1,1,0)); end
  endtask

  initial begin
    test_reset("initial");
    test_tick_basic();
    test_tick_act();
    test_nav();
    test_food();
    test_play();
    test_sleep();
    test_death();
    test_test_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
